usi_timer_block: RTL and testbench
==================================

USI_TIMER_BLOCK -- requirements
Module: usi_timer_block

Interface
REQ-001 The block SHALL have parameter pBlockAdrsMap, default 8, meaning the width of the block-select field in iSUsiAdrs.
REQ-002 The block SHALL have parameter pAdrsMap, default 8'h0A, meaning this block's block-select value.
REQ-003 The block SHALL have parameter pBusAdrsBit, default 16, meaning the USI address width.
REQ-004 The block SHALL have port iSysClk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port iSysRst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port iSUsiWd, input, 32 bits: write data from the master.
REQ-007 The block SHALL have port iSUsiAdrs, input, pBusAdrsBit bits: the upper pBlockAdrsMap bits are block select, the lower 8 bits are register index.
REQ-008 The block SHALL have port iSUsiWCke, input, 1 bit: 1 means a write cycle, 0 means a read cycle.
REQ-009 The block SHALL have port oSUsiRd, output, 32 bits: read data.
REQ-010 The block SHALL have port oSUsiREd, output, 1 bit: read data valid.
REQ-011 The block SHALL have port iCapture, input, 1 bit: asynchronous capture trigger.
REQ-012 The block SHALL have port oTimerIntr, output, 1 bit: level interrupt.

Function
REQ-013 The block SHALL act as a USI responder and decode a hit when the block-select field equals pAdrsMap.
REQ-014 The block SHALL use these register indices: 0 CTRL (bit0 EN, bit1 AUTO, bit2 IRQEN); 1 PRESCALE[15:0]; 2 COMPARE[31:0]; 3 COUNT; 4 STATUS (bit0 MATCH, write-1-to-clear); 5 CAPTURE (read-only).
REQ-015 On a write hit, the addressed register SHALL update on the next clock edge; writes to read-only or undefined indices SHALL be ignored.
REQ-016 On a read hit, oSUsiRd and oSUsiREd SHALL be registered with a latency of exactly 1 cycle; undefined indices SHALL read 0.
REQ-017 When there is no read hit, oSUsiRd SHALL be 0 and oSUsiREd SHALL be 0.
REQ-018 The prescaler SHALL count 0..PRESCALE and emit a one-cycle tick on reaching PRESCALE, then return to 0; PRESCALE=0 SHALL produce a tick every cycle.
REQ-019 The FSM SHALL have states IDLE, RUN and DONE.
REQ-020 FSM transitions: IDLE->RUN when EN is written to 1; RUN->IDLE when EN is written to 0; RUN->DONE on a match with AUTO=0; DONE->RUN when EN is written to 1.
REQ-021 Entering DONE SHALL clear EN; the prescaler SHALL be held at 0 outside RUN.
REQ-022 On a tick in RUN: if COUNT==COMPARE, MATCH SHALL set and COUNT SHALL reload to 0; otherwise COUNT SHALL increment modulo 2^32.
REQ-023 COUNT greater than COMPARE SHALL wrap through 0xFFFFFFFF to 0 and then continue.
REQ-024 When a COUNT write and a tick occur in the same cycle, the written value SHALL win.
REQ-025 When a MATCH set and a STATUS clear occur in the same cycle, the set SHALL win.
REQ-026 oTimerIntr SHALL equal MATCH & IRQEN, registered.

Reset
REQ-027 While iSysRst=1, all registers SHALL be 0, the FSM SHALL be IDLE, the prescaler SHALL be 0, oSUsiRd=0, oSUsiREd=0 and oTimerIntr=0.
REQ-028 Reset asserted mid-count or mid-read SHALL abort the operation and produce no oSUsiREd in the following cycle.

Configuration
REQ-029 With USI_TIMER_CAPTURE_EN defined, iCapture SHALL pass through a 2-flop synchronizer and, on its rising edge, COUNT SHALL be copied into CAPTURE (3 cycles after the input edge).
REQ-030 With USI_TIMER_CAPTURE_EN undefined, iCapture SHALL be ignored, CAPTURE SHALL read 0 and no synchronizer logic SHALL be present.

Structure
REQ-031 The shared package SHALL hold the register index constants, the CTRL/STATUS bit positions and the FSM state encoding.
REQ-032 The block SHALL contain one sub-module, usi_timer_prescaler, holding the prescale counter and tick generation.

Verification
REQ-033 Write PRESCALE=0, COMPARE=3, CTRL=0x7 -> MATCH sets and oTimerIntr rises 4 ticks after EN is written; COUNT then reads 0.
REQ-034 AUTO=0, COMPARE=2, PRESCALE=1 -> the FSM reaches DONE after 6 cycles and CTRL reads EN=0.
REQ-035 Read index 2 after writing 0x12345678 -> oSUsiREd=1 and oSUsiRd=0x12345678 exactly 1 cycle later; a read with a different block select -> oSUsiREd=0 and oSUsiRd=0.
REQ-036 Write STATUS=1 in the same cycle MATCH is set -> MATCH remains 1.
REQ-037 COUNT=0xFFFFFFFF, COMPARE=5 -> COUNT wraps to 0 and MATCH sets at 5.
REQ-038 With USI_TIMER_CAPTURE_EN defined, pulse iCapture when COUNT=10 -> CAPTURE reads 13 (PRESCALE=0).

Source files
------------

// File: rtl/usi_timer_pkg.sv
// usi_timer_pkg: register map, CTRL/STATUS bit positions and FSM encoding for the USI timer
package usi_timer_pkg;
  localparam logic [7:0] IDX_CTRL     = 8'd0;
  localparam logic [7:0] IDX_PRESCALE = 8'd1;
  localparam logic [7:0] IDX_COMPARE  = 8'd2;
  localparam logic [7:0] IDX_COUNT    = 8'd3;
  localparam logic [7:0] IDX_STATUS   = 8'd4;
  localparam logic [7:0] IDX_CAPTURE  = 8'd5;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IRQEN   = 2;
  localparam int STATUS_MATCH = 0;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/usi_timer_prescaler.sv
// usi_timer_prescaler: counts 0..i_prescale while running, one-cycle o_tick at the top
module usi_timer_prescaler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic [15:0] i_prescale,
  output logic        o_tick
);
  logic [15:0] r_cnt;
  // >= keeps the counter sane if PRESCALE is lowered below the current count
  assign o_tick = i_run && (r_cnt >= i_prescale);
  always_ff @(posedge i_clk)
    r_cnt <= (i_rst || !i_run || o_tick) ? 16'd0 : r_cnt + 16'd1;
endmodule

// File: rtl/usi_timer_block.sv
// usi_timer_block: USI-mapped compare timer with IDLE/RUN/DONE FSM and level interrupt.
// Optional input capture (2-flop synchronised) enabled by defining USI_TIMER_CAPTURE_EN.
module usi_timer_block
  import usi_timer_pkg::*;
#(
  parameter int                       pBlockAdrsMap = 8,
  parameter logic [pBlockAdrsMap-1:0] pAdrsMap      = 8'h0A,
  parameter int                       pBusAdrsBit   = 16
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic [31:0]            iSUsiWd,
  input  logic [pBusAdrsBit-1:0] iSUsiAdrs,
  input  logic                   iSUsiWCke,
  output logic [31:0]            oSUsiRd,
  output logic                   oSUsiREd,
  input  logic                   iCapture,
  output logic                   oTimerIntr
);
  state_t      r_state;
  logic [2:0]  r_ctrl, w_ctrl_nxt;
  logic [15:0] r_prescale;
  logic [31:0] r_compare, r_count, w_count_nxt, w_capture, w_rdata, r_rd;
  logic        r_match, w_match_nxt, r_red, r_intr;
  logic        w_hit, w_wr, w_rd, w_ctrl_wr, w_en_wr1, w_en_wr0;
  logic        w_run, w_tick, w_match_ev, w_to_done;
  logic [7:0]  w_idx;
  assign w_hit      = iSUsiAdrs[pBusAdrsBit-1 -: pBlockAdrsMap] == pAdrsMap;
  assign w_idx      = iSUsiAdrs[7:0];
  assign w_wr       = w_hit && iSUsiWCke;
  assign w_rd       = w_hit && !iSUsiWCke;
  assign w_ctrl_wr  = w_wr && (w_idx == IDX_CTRL);
  assign w_en_wr1   = w_ctrl_wr && iSUsiWd[CTRL_EN];
  assign w_en_wr0   = w_ctrl_wr && !iSUsiWd[CTRL_EN];
  assign w_run      = r_state == ST_RUN;
  assign w_match_ev = w_run && w_tick && (r_count == r_compare);
  assign w_to_done  = w_match_ev && !r_ctrl[CTRL_AUTO] && !w_en_wr0;
  // EN self-clears whenever the FSM lands in DONE, even against a concurrent CTRL write
  assign w_ctrl_nxt  = (w_ctrl_wr ? iSUsiWd[2:0] : r_ctrl) & ~(3'(w_to_done) << CTRL_EN);
  assign w_match_nxt = w_match_ev || (r_match && !(w_wr && (w_idx == IDX_STATUS) && iSUsiWd[STATUS_MATCH]));
  assign w_count_nxt = (w_wr && (w_idx == IDX_COUNT)) ? iSUsiWd :
                       (w_run && w_tick) ? (w_match_ev ? 32'd0 : r_count + 32'd1) : r_count;
  assign w_rdata = (w_idx == IDX_CTRL)     ? {29'd0, r_ctrl} :
                   (w_idx == IDX_PRESCALE) ? {16'd0, r_prescale} :
                   (w_idx == IDX_COMPARE)  ? r_compare :
                   (w_idx == IDX_COUNT)    ? r_count :
                   (w_idx == IDX_STATUS)   ? (32'(r_match) << STATUS_MATCH) :
                   (w_idx == IDX_CAPTURE)  ? w_capture : 32'd0;
  usi_timer_prescaler u_prescaler (
    .i_clk      (iSysClk),
    .i_rst      (iSysRst),
    .i_run      (w_run),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_compare  <= '0;
      r_count    <= '0;
      r_match    <= 1'b0;
      r_intr     <= 1'b0;
      r_rd       <= '0;
      r_red      <= 1'b0;
    end else begin
      r_state    <= w_to_done ? ST_DONE :
                    (!w_run && w_en_wr1) ? ST_RUN :
                    (w_run && w_en_wr0) ? ST_IDLE : r_state;
      r_ctrl     <= w_ctrl_nxt;
      r_prescale <= (w_wr && (w_idx == IDX_PRESCALE)) ? iSUsiWd[15:0] : r_prescale;
      r_compare  <= (w_wr && (w_idx == IDX_COMPARE)) ? iSUsiWd : r_compare;
      r_count    <= w_count_nxt;
      r_match    <= w_match_nxt;
      r_intr     <= w_match_nxt && w_ctrl_nxt[CTRL_IRQEN];
      r_rd       <= w_rd ? w_rdata : 32'd0;
      r_red      <= w_rd;
    end
  end
`ifdef USI_TIMER_CAPTURE_EN
  logic [1:0]  r_sync;
  logic        r_sync_d;
  logic [31:0] r_capture;
  // Snapshot the value COUNT takes on the capturing edge
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_sync    <= '0;
      r_sync_d  <= 1'b0;
      r_capture <= '0;
    end else begin
      r_sync    <= {r_sync[0], iCapture};
      r_sync_d  <= r_sync[1];
      r_capture <= (r_sync[1] && !r_sync_d) ? w_count_nxt : r_capture;
    end
  end
  assign w_capture = r_capture;
`else
  logic w_unused_capture;
  assign w_unused_capture = iCapture;
  assign w_capture = 32'd0;
`endif
  assign oSUsiRd    = r_rd;
  assign oSUsiREd   = r_red;
  assign oTimerIntr = r_intr;
endmodule

// File: tb/tb_usi_timer_block.sv
// tb_usi_timer_block: directed self-checking bench for usi_timer_block
module tb_usi_timer_block;
  import usi_timer_pkg::*;
  logic        iSysClk = 1'b0;
  logic        iSysRst = 1'b1;
  logic [31:0] iSUsiWd = '0;
  logic [15:0] iSUsiAdrs = '0;
  logic        iSUsiWCke = 1'b0;
  logic [31:0] oSUsiRd;
  logic        oSUsiREd;
  logic        iCapture = 1'b0;
  logic        oTimerIntr;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] rd_data;
  logic        rd_vld;

  usi_timer_block dut (
    .iSysClk    (iSysClk),
    .iSysRst    (iSysRst),
    .iSUsiWd    (iSUsiWd),
    .iSUsiAdrs  (iSUsiAdrs),
    .iSUsiWCke  (iSUsiWCke),
    .oSUsiRd    (oSUsiRd),
    .oSUsiREd   (oSUsiREd),
    .iCapture   (iCapture),
    .oTimerIntr (oTimerIntr)
  );

  always #5 iSysClk = ~iSysClk;

  task automatic step();
    @(posedge iSysClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    iSUsiAdrs = 16'h0000;
    iSUsiWCke = 1'b0;
    iSUsiWd   = '0;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [31:0] d);
    iSUsiAdrs = {8'h0A, idx};
    iSUsiWCke = 1'b1;
    iSUsiWd   = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [7:0] idx);
    iSUsiAdrs = {8'h0A, idx};
    iSUsiWCke = 1'b0;
    step();
    rd_data = oSUsiRd;
    rd_vld  = oSUsiREd;
    idle();
  endtask

  task automatic rdchk(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    rd(idx);
    chk({tag, ".vld"}, 32'(rd_vld), 32'd1);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    // reset state, including a read hit held during reset
    iSUsiAdrs = {8'h0A, IDX_COMPARE};
    repeat (3) step();
    chk("rst_red", 32'(oSUsiREd), 32'd0);
    chk("rst_rd", oSUsiRd, 32'd0);
    chk("rst_intr", 32'(oTimerIntr), 32'd0);
    idle();
    iSysRst = 1'b0;
    rdchk("rst_ctrl", IDX_CTRL, 32'd0);
    rdchk("rst_count", IDX_COUNT, 32'd0);
    // register access, read latency, foreign block select, undefined/read-only indices
    wr(IDX_COMPARE, 32'h12345678);
    rdchk("rd_compare", IDX_COMPARE, 32'h12345678);
    step();
    chk("no_rd_red", 32'(oSUsiREd), 32'd0);
    chk("no_rd_rd", oSUsiRd, 32'd0);
    iSUsiAdrs = 16'h0B02;
    step();
    chk("other_blk_red", 32'(oSUsiREd), 32'd0);
    chk("other_blk_rd", oSUsiRd, 32'd0);
    idle();
    rdchk("undef_idx", 8'd7, 32'd0);
    wr(IDX_CAPTURE, 32'hDEADBEEF);
    rdchk("capture_ro", IDX_CAPTURE, 32'd0);
    wr(IDX_PRESCALE, 32'h0001ABCD);
    rdchk("prescale_16b", IDX_PRESCALE, 32'h0000ABCD);
    // AUTO run: PRESCALE=0, COMPARE=3 -> match on 4th tick
    wr(IDX_PRESCALE, 32'd0);
    wr(IDX_COMPARE, 32'd3);
    wr(IDX_CTRL, 32'h7);
    repeat (3) step();
    chk("intr_early", 32'(oTimerIntr), 32'd0);
    step();
    chk("intr_rise", 32'(oTimerIntr), 32'd1);
    rdchk("count_reload", IDX_COUNT, 32'd0);
    rdchk("status_match", IDX_STATUS, 32'd1);
    wr(IDX_STATUS, 32'd1);
    chk("w1c_intr", 32'(oTimerIntr), 32'd0);
    wr(IDX_STATUS, 32'd1);
    chk("set_wins_intr", 32'(oTimerIntr), 32'd1);
    rdchk("set_wins_status", IDX_STATUS, 32'd1);
    wr(IDX_CTRL, 32'h0);
    rdchk("stop_count", IDX_COUNT, 32'd2);
    wr(IDX_STATUS, 32'd1);
    // one-shot: PRESCALE=1, COMPARE=2 -> DONE six cycles after EN
    wr(IDX_COUNT, 32'd0);
    wr(IDX_PRESCALE, 32'd1);
    wr(IDX_COMPARE, 32'd2);
    wr(IDX_CTRL, 32'h1);
    repeat (4) step();
    rdchk("ctrl_c5", IDX_CTRL, 32'd1);
    rdchk("ctrl_c6", IDX_CTRL, 32'd1);
    rdchk("ctrl_done", IDX_CTRL, 32'd0);
    rdchk("done_status", IDX_STATUS, 32'd1);
    repeat (3) step();
    rdchk("done_hold", IDX_COUNT, 32'd0);
    chk("no_irqen_intr", 32'(oTimerIntr), 32'd0);
    // COUNT write beats a simultaneous tick
    wr(IDX_STATUS, 32'd1);
    wr(IDX_PRESCALE, 32'd0);
    wr(IDX_COMPARE, 32'd100);
    wr(IDX_CTRL, 32'h1);
    wr(IDX_COUNT, 32'd50);
    rdchk("count_wr_wins", IDX_COUNT, 32'd50);
    // wrap from 0xFFFFFFFF, match at 5
    wr(IDX_CTRL, 32'h0);
    wr(IDX_COMPARE, 32'd5);
    wr(IDX_COUNT, 32'hFFFFFFFF);
    wr(IDX_CTRL, 32'h5);
    rdchk("wrap_pre", IDX_COUNT, 32'hFFFFFFFF);
    rdchk("wrap_zero", IDX_COUNT, 32'd0);
    repeat (4) step();
    chk("wrap_intr_early", 32'(oTimerIntr), 32'd0);
    step();
    chk("wrap_intr", 32'(oTimerIntr), 32'd1);
    rdchk("wrap_ctrl", IDX_CTRL, 32'd4);
    rdchk("wrap_count", IDX_COUNT, 32'd0);
`ifdef USI_TIMER_CAPTURE_EN
    wr(IDX_STATUS, 32'd1);
    wr(IDX_COMPARE, 32'd1000);
    wr(IDX_COUNT, 32'd0);
    wr(IDX_CTRL, 32'h1);
    repeat (10) step();
    iCapture = 1'b1;
    repeat (3) step();
    iCapture = 1'b0;
    rdchk("capture", IDX_CAPTURE, 32'd13);
`else
    iCapture = 1'b1;
    repeat (4) step();
    iCapture = 1'b0;
    rdchk("capture_off", IDX_CAPTURE, 32'd0);
`endif
    // reset aborts an in-flight read
    iSUsiAdrs = {8'h0A, IDX_COMPARE};
    iSUsiWCke = 1'b0;
    iSysRst   = 1'b1;
    step();
    chk("rst_mid_red", 32'(oSUsiREd), 32'd0);
    chk("rst_mid_rd", oSUsiRd, 32'd0);
    chk("rst_mid_intr", 32'(oTimerIntr), 32'd0);
    idle();
    step();
    iSysRst = 1'b0;
    rdchk("rst2_compare", IDX_COMPARE, 32'd0);
    rdchk("rst2_ctrl", IDX_CTRL, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
